// File: rtl/display_7seg_words.sv
// Front-panel word generator: turns the 2-bit controller mode into a registered
// four-character word on the 7-segment digits (digit 3 leftmost).
module display_7seg_words #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    output logic [6:0] display_words_3,
    output logic [6:0] display_words_2,
    output logic [6:0] display_words_1,
    output logic [6:0] display_words_0
);

    typedef enum logic [3:0] {
        CH_BLANK = 4'd0,
        CH_H     = 4'd1,
        CH_E     = 4'd2,
        CH_A     = 4'd3,
        CH_T     = 4'd4,
        CH_D     = 4'd5,
        CH_O_LC  = 4'd6,
        CH_N     = 4'd7,
        CH_O_UC  = 4'd8,
        CH_P     = 4'd9
    } char_e;

    // XOR mask turns the active-high glyph into the board's drive polarity;
    // it also makes the blank pattern all-ones on a common-anode board.
    localparam logic [6:0] POLARITY_MASK = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] BLANK_PATTERN = POLARITY_MASK;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input char_e ch);
        logic [6:0] seg;
        seg = 7'h00;
        case (ch)
            CH_H:    seg = 7'h76;
            CH_E:    seg = 7'h79;
            CH_A:    seg = 7'h77;
            CH_T:    seg = 7'h78;
            CH_D:    seg = 7'h5E;
            CH_O_LC: seg = 7'h5C;
            CH_N:    seg = 7'h54;
            CH_O_UC: seg = 7'h3F;
            CH_P:    seg = 7'h73;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    char_e char_3;
    char_e char_2;
    char_e char_1;
    char_e char_0;

    always_comb begin
        char_3 = CH_BLANK;
        char_2 = CH_BLANK;
        char_1 = CH_BLANK;
        char_0 = CH_BLANK;
        case (mode)
            2'b01: begin
                char_3 = CH_H;
                char_2 = CH_E;
                char_1 = CH_A;
                char_0 = CH_T;
            end
            2'b10: begin
                char_3 = CH_D;
                char_2 = CH_O_LC;
                char_1 = CH_N;
                char_0 = CH_E;
            end
            2'b11: begin
                char_3 = CH_O_UC;
                char_2 = CH_P;
                char_1 = CH_E;
                char_0 = CH_N;
            end
            default: begin
                char_3 = CH_BLANK;
                char_2 = CH_BLANK;
                char_1 = CH_BLANK;
                char_0 = CH_BLANK;
            end
        endcase
    end

    logic [6:0] digit_3_d;
    logic [6:0] digit_2_d;
    logic [6:0] digit_1_d;
    logic [6:0] digit_0_d;
    logic [6:0] digit_3_q;
    logic [6:0] digit_2_q;
    logic [6:0] digit_1_q;
    logic [6:0] digit_0_q;

    always_comb begin
        digit_3_d = glyph(char_3) ^ POLARITY_MASK;
        digit_2_d = glyph(char_2) ^ POLARITY_MASK;
        digit_1_d = glyph(char_1) ^ POLARITY_MASK;
        digit_0_d = glyph(char_0) ^ POLARITY_MASK;
    end

    // All four digits share one register stage so a word change is atomic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_3_q <= BLANK_PATTERN;
            digit_2_q <= BLANK_PATTERN;
            digit_1_q <= BLANK_PATTERN;
            digit_0_q <= BLANK_PATTERN;
        end else begin
            digit_3_q <= digit_3_d;
            digit_2_q <= digit_2_d;
            digit_1_q <= digit_1_d;
            digit_0_q <= digit_0_d;
        end
    end

    assign display_words_3 = digit_3_q;
    assign display_words_2 = digit_2_q;
    assign display_words_1 = digit_1_q;
    assign display_words_0 = digit_0_q;

endmodule

// File: tb/tb_display_7seg_words.sv
// Directed bench for display_7seg_words: checks a common-anode build and an
// active-high build side by side against hand-computed segment words.
module tb_display_7seg_words;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [6:0] l_d3, l_d2, l_d1, l_d0;
    logic [6:0] h_d3, h_d2, h_d1, h_d0;

    int tests_run;
    int tests_failed;

    // Words packed {digit3,digit2,digit1,digit0}, 7 bits each.
    localparam logic [27:0] L_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
    localparam logic [27:0] L_HEAT  = {7'h09, 7'h06, 7'h08, 7'h07};
    localparam logic [27:0] L_DONE  = {7'h21, 7'h23, 7'h2B, 7'h06};
    localparam logic [27:0] L_OPEN  = {7'h40, 7'h0C, 7'h06, 7'h2B};
    localparam logic [27:0] H_BLANK = {7'h00, 7'h00, 7'h00, 7'h00};
    localparam logic [27:0] H_HEAT  = {7'h76, 7'h79, 7'h77, 7'h78};
    localparam logic [27:0] H_DONE  = {7'h5E, 7'h5C, 7'h54, 7'h79};
    localparam logic [27:0] H_OPEN  = {7'h3F, 7'h73, 7'h79, 7'h54};

    logic [27:0] obs_l;
    logic [27:0] obs_h;
    assign obs_l = {l_d3, l_d2, l_d1, l_d0};
    assign obs_h = {h_d3, h_d2, h_d1, h_d0};

    display_7seg_words #(.ACTIVE_LOW(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mode            (mode),
        .display_words_3 (l_d3),
        .display_words_2 (l_d2),
        .display_words_1 (l_d1),
        .display_words_0 (l_d0)
    );

    display_7seg_words #(.ACTIVE_LOW(1'b0)) dut_ah (
        .clk             (clk),
        .rst_n           (rst_n),
        .mode            (mode),
        .display_words_3 (h_d3),
        .display_words_2 (h_d2),
        .display_words_1 (h_d1),
        .display_words_0 (h_d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        // First rising edge is at t=5; assert reset at t=2 and look at t=3.
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs_l !== L_BLANK) begin
            tests_failed++;
            $display("[TB] FAIL reset_async_low: got %h want %h", obs_l, L_BLANK);
        end
        tests_run++;
        if (obs_h !== H_BLANK) begin
            tests_failed++;
            $display("[TB] FAIL reset_async_high: got %h want %h", obs_h, H_BLANK);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (obs_l !== L_BLANK) begin
            tests_failed++;
            $display("[TB] FAIL reset_held: got %h want %h", obs_l, L_BLANK);
        end
    endtask

    task automatic test_heat();
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 2'b01;
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_l !== L_HEAT) begin
            tests_failed++;
            $display("[TB] FAIL heat_low: got %h want %h", obs_l, L_HEAT);
        end
        tests_run++;
        if (obs_h !== H_HEAT) begin
            tests_failed++;
            $display("[TB] FAIL heat_high: got %h want %h", obs_h, H_HEAT);
        end
    endtask

    task automatic test_done_latency();
        @(negedge clk);
        mode = 2'b10;
        #1;
        tests_run++;
        if (obs_l !== L_HEAT) begin
            tests_failed++;
            $display("[TB] FAIL done_before_edge: got %h want %h", obs_l, L_HEAT);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_l !== L_DONE) begin
            tests_failed++;
            $display("[TB] FAIL done_low: got %h want %h", obs_l, L_DONE);
        end
        tests_run++;
        if (obs_h !== H_DONE) begin
            tests_failed++;
            $display("[TB] FAIL done_high: got %h want %h", obs_h, H_DONE);
        end
    endtask

    task automatic test_mid_cycle_mode();
        // Mode wiggles between edges but is back to 2'b10 at the edge.
        @(negedge clk);
        mode = 2'b11;
        #1 mode = 2'b00;
        #1 mode = 2'b10;
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_l !== L_DONE) begin
            tests_failed++;
            $display("[TB] FAIL mode_glitch_ignored: got %h want %h", obs_l, L_DONE);
        end
    endtask

    task automatic test_open_blank();
        @(negedge clk);
        mode = 2'b11;
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_l !== L_OPEN) begin
            tests_failed++;
            $display("[TB] FAIL open_low: got %h want %h", obs_l, L_OPEN);
        end
        tests_run++;
        if (obs_h !== H_OPEN) begin
            tests_failed++;
            $display("[TB] FAIL open_high: got %h want %h", obs_h, H_OPEN);
        end
        @(negedge clk);
        mode = 2'b00;
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_l !== L_BLANK) begin
            tests_failed++;
            $display("[TB] FAIL blank_mode_low: got %h want %h", obs_l, L_BLANK);
        end
        tests_run++;
        if (obs_h !== H_BLANK) begin
            tests_failed++;
            $display("[TB] FAIL blank_mode_high: got %h want %h", obs_h, H_BLANK);
        end
    endtask

    task automatic test_reset_pulse();
        @(negedge clk);
        mode = 2'b11;
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_l !== L_OPEN) begin
            tests_failed++;
            $display("[TB] FAIL pulse_pre_open: got %h want %h", obs_l, L_OPEN);
        end
        #1 rst_n = 1'b0;
        mode = 2'bxx;
        #1;
        tests_run++;
        if (obs_l !== L_BLANK) begin
            tests_failed++;
            $display("[TB] FAIL pulse_blank_low: got %h want %h", obs_l, L_BLANK);
        end
        tests_run++;
        if (obs_h !== H_BLANK) begin
            tests_failed++;
            $display("[TB] FAIL pulse_blank_high: got %h want %h", obs_h, H_BLANK);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_l !== L_BLANK) begin
            tests_failed++;
            $display("[TB] FAIL pulse_x_mode_in_reset: got %h want %h", obs_l, L_BLANK);
        end
        @(negedge clk);
        mode  = 2'b11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_l !== L_OPEN) begin
            tests_failed++;
            $display("[TB] FAIL pulse_release_open: got %h want %h", obs_l, L_OPEN);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  seq_mode [6];
        logic [27:0] seq_l    [6];
        logic [27:0] seq_h    [6];
        seq_mode = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10};
        seq_l    = '{L_HEAT, L_OPEN, L_DONE, L_BLANK, L_HEAT, L_DONE};
        seq_h    = '{H_HEAT, H_OPEN, H_DONE, H_BLANK, H_HEAT, H_DONE};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mode = seq_mode[i];
            @(posedge clk);
            #1;
            tests_run++;
            if (obs_l !== seq_l[i] || obs_h !== seq_h[i]) begin
                tests_failed++;
                $display("[TB] FAIL b2b_step%0d: got %h/%h want %h/%h",
                         i, obs_l, obs_h, seq_l[i], seq_h[i]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b1;
        mode         = 2'b01;
        test_reset();
        test_heat();
        test_done_latency();
        test_mid_cycle_mode();
        test_open_blank();
        test_reset_pulse();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
